// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter/sequencer sharing one bitwise logic unit between two requesters
//
// Purpose: accepts {a, b, op} commands from two requesters, drives the shared
// logic unit for ALU_LAT cycles, captures its result and returns it to the
// requester that owns the transaction. One transaction is in flight at a time.
//
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   req{0,1}_valid/_ready        command handshake
//   req{0,1}_a/_b/_op            command operands and op select
//   rsp{0,1}_valid/_ready/_f     response handshake and result
//   alu_a/_b/_op, alu_f          shared logic unit interface
//   busy                         a transaction is in progress

module logic_unit_arbiter #(
  parameter int W       = 2,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_op,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_f,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_f,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_f,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  state_e       state_q;
  logic         last_grant_q;
  logic         id_q;
  logic [2:0]   cnt_q;
  logic [W-1:0] alu_a_q;
  logic [W-1:0] alu_b_q;
  logic [1:0]   alu_op_q;
  logic [W-1:0] result_q;
  logic         rsp0_valid_q;
  logic         rsp1_valid_q;
  logic         busy_q;

  logic grant;
  logic accept;
  logic rsp_done;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept   = (state_q == IDLE) && (req0_valid || req1_valid);
  assign rsp_done = id_q ? rsp1_ready : rsp0_ready;

  // Ready is combinational from valid, so it is qualified by rst_n to keep
  // every output low while reset is held.
  assign req0_ready = rst_n && accept && !grant;
  assign req1_ready = rst_n && accept && grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      cnt_q        <= 3'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 2'b00;
      result_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            // The alu_* registers double as the command latch.
            id_q     <= grant;
            alu_a_q  <= grant ? req1_a  : req0_a;
            alu_b_q  <= grant ? req1_b  : req0_b;
            alu_op_q <= grant ? req1_op : req0_op;
            cnt_q    <= LAT_INIT;
            busy_q   <= 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            // Only the last EXEC cycle's alu_f is trusted.
            result_q     <= alu_f;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 2'b00;
            rsp0_valid_q <= !id_q;
            rsp1_valid_q <= id_q;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (rsp_done) begin
            last_grant_q <= id_q;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_f     = result_q;
  assign rsp1_f     = result_q;
  assign busy       = busy_q;

endmodule
